ps_decoder: RTL and testbench
=============================

# ps_decoder

Power-stage-side receiver for the rocking-motor drive link. It decodes the two PWM-encoded lines `PSfreq` and `PSamp` (produced by the `Output` block from the controller's 3-bit `freq`/`amp` levels) back into 3-bit levels. It checks frame timing and reports framing errors and link loss. It sits on the power-stage board, or in loop-back test benches, at the far end of the `Output` → power-stage interface.

## Interface

Parameters
- `UNIT`, 1000: clocks per duty step; frame period is 9*`UNIT`.
- `TOL`, 50: ± tolerance in clocks on every width and period check; must satisfy `TOL` < `UNIT`/2.

Ports
- `clk`  in  1  system clock; only clock.
- `reset`  in  1  synchronous, active-low reset.
- `PSfreq`  in  1  asynchronous frequency PWM line.
- `PSamp`  in  1  asynchronous amplitude PWM line.
- `freq`  out  3  last accepted frequency level.
- `amp`  out  3  last accepted amplitude level.
- `freqValid`  out  1  frequency channel locked, last frame good.
- `ampValid`  out  1  amplitude channel locked, last frame good.
- `freqNew`  out  1  one-cycle strobe when `freq` is committed.
- `ampNew`  out  1  one-cycle strobe when `amp` is committed.
- `error`  out  1  one-cycle pulse on any framing error or timeout, OR of both channels.

## Operation

- Line encoding: a frame starts on a rising edge and the period is 9*`UNIT`. High time is (L+1)*`UNIT` for level L in 0..7. The low gap is therefore always ≥ `UNIT`.
- Each input passes through a 2-flop synchronizer (reset value 0), then a rising/falling edge detector.
- Two identical, independent channel engines run in parallel. They share no state except the ORed `error`.
- Per-channel counters:
  - `hcnt`: high time.
  - `pcnt`: clocks since last accepted rising edge.
  - Both saturate, width ≥ clog2(18*`UNIT`+1).
- Channel FSM:
  - WAIT_RISE (reset state): ignore falling edges and high level.
    - On rising edge: clear `hcnt`/`pcnt`, go HIGH.
  - HIGH: count `hcnt`.
    - On falling edge: if `hcnt` is within (L+1)*`UNIT` ± `TOL` for some L, commit L to the level output, set valid, pulse New, go LOW.
    - If no such L on the falling edge: pulse error, clear valid, go WAIT_RISE.
    - If `hcnt` exceeds 8*`UNIT`+`TOL` while still high: pulse error, clear valid, go WAIT_RISE. A fresh rising edge is required to recover.
  - LOW, on rising edge:
    - If `pcnt` is within 9*`UNIT` ± `TOL`: restart counters, go HIGH.
    - Otherwise: pulse error, clear valid, keep the level output, restart counters, go HIGH. The new edge starts a new frame.
  - Timeout, in any state except WAIT_RISE: `pcnt` reaches 2*9*`UNIT`. Then pulse error, clear valid, force level to 0, go WAIT_RISE.
- Valid rules:
  - Valid sets only on a commit.
  - Valid clears on any error or timeout.
  - Level outputs hold between commits.
- Simultaneous events on the two channels are fully independent. Both error conditions in the same cycle give a single `error` pulse.

## Timing

- Reset: when `reset`=0 at a clock edge, all outputs go to 0, both FSMs go to WAIT_RISE, counters and synchronizers clear. Reset mid-frame discards that frame.
- A line already high when reset releases is ignored until it goes low and then high again.
- Synchronizer plus edge detect: the edge is recognised 3 clocks after the input transition.
- Commit: the level, valid and New strobe update on the same clock edge as the recognised falling edge.
- `error` asserts on the same clock edge as the detecting condition and lasts exactly 1 cycle.
- New strobes last exactly 1 cycle and fire once per good frame, even if the level is unchanged.
- The first good frame after reset or timeout commits at its falling edge. There is no period check for that frame.

## Test plan

Bench parameters: `UNIT`=10, `TOL`=2, frame = 90 clocks.

- Reset: hold `reset`=0 for 5 cycles with both lines toggling → all outputs 0. Release with `PSamp` high → no commit until after a 0→1 transition.
- Nominal: `PSfreq` sends frames of high 40 / period 90, repeated → `freq`=3, `freqValid`=1 after the first falling edge plus 3 clocks, and `freqNew` pulses once per frame. In parallel, `PSamp` sends high 80 → `amp`=7.
- Tolerance edges:
  - High 22 → level 1 accepted; high 23 → `error` pulse and `freqValid`=0.
  - Period 92 accepted; period 93 → `error` pulse, `freq` held, the next good frame re-commits and sets valid.
- Stuck high: line held high for 100 clocks → `error` pulse when `hcnt`=83. Then valid=0, and no commit until a low→high transition followed by a good frame.
- Timeout: after a good level 5, the line is held low → `error` pulse 180 clocks after the last rising edge, and `amp`=0, `ampValid`=0.
- Reset mid-frame: assert `reset` 20 clocks into a high pulse → all outputs 0. The next full good frame commits normally.

Source files
------------

// File: rtl/ps_decoder.sv
// ps_decoder: power-stage receiver for the rocking-motor drive link.
// Decodes the PWM lines PSfreq/PSamp back into 3-bit levels. Each frame starts
// on a rising edge, has a period of 9*UNIT and a high time of (L+1)*UNIT.
// Checks high time, period and link timeout, and reports framing errors.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   PSfreq     asynchronous frequency PWM line
//   PSamp      asynchronous amplitude PWM line
//   freq/amp   last accepted level per channel
//   freqValid  frequency channel locked, last frame good
//   ampValid   amplitude channel locked, last frame good
//   freqNew    one-cycle strobe on frequency commit
//   ampNew     one-cycle strobe on amplitude commit
//   error      one-cycle pulse on any framing error or timeout (both channels)
//
// TOL must be less than UNIT/2 so that the level windows do not overlap.

// ps_channel: one line's synchronizer, edge detector and frame checker.
// Ports: clk, reset (sync active-low), line (async input), level/valid/strobe
// (registered results), err_c (combinational error condition for this cycle).
module ps_channel #(
   parameter int unsigned UNIT = 1000,
   parameter int unsigned TOL  = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       line,
   output logic [2:0] level,
   output logic       valid,
   output logic       strobe,
   output logic       err_c
);

   localparam int unsigned FRAME = 9 * UNIT;
   localparam int unsigned TMO   = 2 * FRAME;
   localparam int unsigned CW    = $clog2(TMO + 2);

   localparam logic [CW-1:0] CMAX = '1;
   localparam logic [CW-1:0] HMAX = CW'(8 * UNIT + TOL);
   localparam logic [CW-1:0] PLO  = CW'(FRAME - TOL);
   localparam logic [CW-1:0] PHI  = CW'(FRAME + TOL);
   localparam logic [CW-1:0] TLIM = CW'(TMO);

   localparam logic [1:0] WAIT_RISE = 2'd0;
   localparam logic [1:0] HIGH      = 2'd1;
   localparam logic [1:0] LOW       = 2'd2;

   logic          s1, s2, prev, arm;
   logic [1:0]    fill;
   logic          rise_c, fall_c;

   logic [1:0]    state, state_n;
   logic [CW-1:0] hcnt, hcnt_n, pcnt, pcnt_n;
   logic [CW-1:0] hmeas_c, pmeas_c;
   logic [2:0]    level_n, hlvl_c;
   logic          valid_n, strobe_n, hit_c;

   // Synchronizer and edge detector. arm holds off rising edges until the
   // synchronized line has been seen low after reset, so a line that is
   // already high at release must go low and high again first.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
         fill <= 2'b00;
         arm  <= 1'b0;
      end else begin
         s1   <= line;
         s2   <= s1;
         prev <= s2;
         fill <= {fill[0], 1'b1};
         arm  <= arm | (fill[1] & ~s2);
      end
   end

   assign rise_c = s2 & ~prev & arm;
   assign fall_c = ~s2 & prev;

   // Counters hold clocks elapsed minus one; the measured value includes the
   // current cycle and saturates.
   assign hmeas_c = (hcnt == CMAX) ? CMAX : hcnt + CW'(1);
   assign pmeas_c = (pcnt == CMAX) ? CMAX : pcnt + CW'(1);

   // Map the measured high time onto a level window.
   always_comb begin
      hit_c  = 1'b0;
      hlvl_c = 3'd0;
      for (int l = 0; l < 8; l++) begin
         if (hmeas_c >= CW'((l + 1) * UNIT - TOL) &&
             hmeas_c <= CW'((l + 1) * UNIT + TOL)) begin
            hit_c  = 1'b1;
            hlvl_c = 3'(l);
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= WAIT_RISE;
         hcnt   <= '0;
         pcnt   <= '0;
         level  <= 3'd0;
         valid  <= 1'b0;
         strobe <= 1'b0;
      end else begin
         state  <= state_n;
         hcnt   <= hcnt_n;
         pcnt   <= pcnt_n;
         level  <= level_n;
         valid  <= valid_n;
         strobe <= strobe_n;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_n  = state;
      hcnt_n   = hcnt;
      pcnt_n   = pcnt;
      level_n  = level;
      valid_n  = valid;
      strobe_n = 1'b0;
      err_c    = 1'b0;

      case (state)
         WAIT_RISE: begin
            if (rise_c) begin
               hcnt_n  = '0;
               pcnt_n  = '0;
               state_n = HIGH;
            end
         end
         HIGH: begin
            hcnt_n = hmeas_c;
            pcnt_n = pmeas_c;
            if (fall_c) begin
               if (hit_c) begin
                  level_n  = hlvl_c;
                  valid_n  = 1'b1;
                  strobe_n = 1'b1;
                  state_n  = LOW;
               end else begin
                  err_c   = 1'b1;
                  valid_n = 1'b0;
                  state_n = WAIT_RISE;
               end
            end else if (hmeas_c > HMAX) begin
               err_c   = 1'b1;
               valid_n = 1'b0;
               state_n = WAIT_RISE;
            end
         end
         LOW: begin
            pcnt_n = pmeas_c;
            if (rise_c) begin
               // A bad period still starts a new frame on this edge.
               if (pmeas_c < PLO || pmeas_c > PHI) begin
                  err_c   = 1'b1;
                  valid_n = 1'b0;
               end
               hcnt_n  = '0;
               pcnt_n  = '0;
               state_n = HIGH;
            end
         end
         default: state_n = WAIT_RISE;
      endcase

      // Link loss overrides everything else and drops the level.
      if (state != WAIT_RISE && pmeas_c >= TLIM) begin
         err_c    = 1'b1;
         valid_n  = 1'b0;
         strobe_n = 1'b0;
         level_n  = 3'd0;
         state_n  = WAIT_RISE;
      end
   end

endmodule

// Top: two independent channels sharing only the registered error pulse.
module ps_decoder #(
   parameter int unsigned UNIT = 1000,
   parameter int unsigned TOL  = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       PSfreq,
   input  logic       PSamp,
   output logic [2:0] freq,
   output logic [2:0] amp,
   output logic       freqValid,
   output logic       ampValid,
   output logic       freqNew,
   output logic       ampNew,
   output logic       error
);

   logic freq_err_c, amp_err_c;

   ps_channel #(.UNIT(UNIT), .TOL(TOL)) u_freq (
      .clk    (clk),
      .reset  (reset),
      .line   (PSfreq),
      .level  (freq),
      .valid  (freqValid),
      .strobe (freqNew),
      .err_c  (freq_err_c)
   );

   ps_channel #(.UNIT(UNIT), .TOL(TOL)) u_amp (
      .clk    (clk),
      .reset  (reset),
      .line   (PSamp),
      .level  (amp),
      .valid  (ampValid),
      .strobe (ampNew),
      .err_c  (amp_err_c)
   );

   // Simultaneous channel errors merge into one pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         error <= 1'b0;
      end else begin
         error <= freq_err_c | amp_err_c;
      end
   end

endmodule

// File: tb/tb_ps_decoder.sv
// Bench for ps_decoder with UNIT=10, TOL=2 (frame = 90 clocks).
module tb_ps_decoder;

   logic       clk;
   logic       reset;
   logic       psfreq, psamp;
   logic [2:0] freq, amp;
   logic       freqValid, ampValid, freqNew, ampNew, error;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int         cyc;
      logic [1:0] mask;
      logic [2:0] lf;
      logic [2:0] la;
   } ev_t;

   ev_t q_f[$];
   ev_t q_a[$];
   ev_t q_e[$];

   ps_decoder #(.UNIT(10), .TOL(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .PSfreq    (psfreq),
      .PSamp     (psamp),
      .freq      (freq),
      .amp       (amp),
      .freqValid (freqValid),
      .ampValid  (ampValid),
      .freqNew   (freqNew),
      .ampNew    (ampNew),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void push_f(input int c, input logic [2:0] l);
      ev_t e;
      e.cyc = c; e.mask = 2'b01; e.lf = l; e.la = 3'd0;
      q_f.push_back(e);
   endfunction

   function automatic void push_a(input int c, input logic [2:0] l);
      ev_t e;
      e.cyc = c; e.mask = 2'b10; e.lf = 3'd0; e.la = l;
      q_a.push_back(e);
   endfunction

   function automatic void push_err(input int c, input logic [1:0] m,
                                    input logic [2:0] lf, input logic [2:0] la);
      ev_t e;
      e.cyc = c; e.mask = m; e.lf = lf; e.la = la;
      q_e.push_back(e);
   endfunction

   // Monitor: retire overdue expectations, then match every output pulse.
   always @(negedge clk) begin : mon
      ev_t e;
      while (q_f.size() > 0 && q_f[0].cyc < cyc) begin
         n_checks++; n_fail++;
         $display("FAIL freqNew_missing: expected at cycle %0d, none by cycle %0d", q_f[0].cyc, cyc);
         void'(q_f.pop_front());
      end
      while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
         n_checks++; n_fail++;
         $display("FAIL ampNew_missing: expected at cycle %0d, none by cycle %0d", q_a[0].cyc, cyc);
         void'(q_a.pop_front());
      end
      while (q_e.size() > 0 && q_e[0].cyc < cyc) begin
         n_checks++; n_fail++;
         $display("FAIL error_missing: expected at cycle %0d, none by cycle %0d", q_e[0].cyc, cyc);
         void'(q_e.pop_front());
      end

      if (freqNew === 1'b1) begin
         if (q_f.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL freqNew_unexpected: pulse at cycle %0d, none required", cyc);
         end else begin
            e = q_f.pop_front();
            chk("freqNew_cycle", cyc, e.cyc);
            chk("freq_level", int'(freq), int'(e.lf));
            chk("freqValid_on_commit", int'(freqValid), 1);
         end
      end

      if (ampNew === 1'b1) begin
         if (q_a.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL ampNew_unexpected: pulse at cycle %0d, none required", cyc);
         end else begin
            e = q_a.pop_front();
            chk("ampNew_cycle", cyc, e.cyc);
            chk("amp_level", int'(amp), int'(e.la));
            chk("ampValid_on_commit", int'(ampValid), 1);
         end
      end

      if (error === 1'b1) begin
         if (q_e.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL error_unexpected: pulse at cycle %0d, none required", cyc);
         end else begin
            e = q_e.pop_front();
            chk("error_cycle", cyc, e.cyc);
            if (e.mask[0]) begin
               chk("freq_after_error", int'(freq), int'(e.lf));
               chk("freqValid_after_error", int'(freqValid), 0);
            end
            if (e.mask[1]) begin
               chk("amp_after_error", int'(amp), int'(e.la));
               chk("ampValid_after_error", int'(ampValid), 0);
            end
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One frame on one line: high for 'high' clocks, total length 'len'.
   task automatic frame(input bit ch, input int high, input int len);
      if (ch) psamp = 1'b1; else psfreq = 1'b1;
      hold(high);
      if (ch) psamp = 1'b0; else psfreq = 1'b0;
      hold(len - high);
   endtask

   function automatic int outs();
      return int'({freq, amp, freqValid, ampValid, freqNew, ampNew, error});
   endfunction

   task automatic do_reset(input string name);
      reset = 1'b0;
      hold(3);
      chk(name, outs(), 0);
      reset = 1'b1;
      hold(5);
   endtask

   initial begin : stim
      int b;
      reset  = 1'b0;
      psfreq = 1'b0;
      psamp  = 1'b0;
      hold(1);

      // Reset with toggling lines, release with PSamp already high.
      for (int i = 0; i < 5; i++) begin
         psfreq = ~psfreq;
         psamp  = psfreq;
         hold(1);
      end
      chk("reset_toggling", outs(), 0);
      psfreq = 1'b0;
      psamp  = 1'b1;
      hold(2);
      reset = 1'b1;
      hold(40);
      psamp = 1'b0;
      hold(50);
      b = cyc;
      push_a(b + 33, 3'd2);
      frame(1'b1, 30, 70);
      do_reset("reset_after_release_test");

      // Nominal: freq high 40 (level 3), amp high 80 (level 7), period 90.
      for (int k = 0; k < 3; k++) begin
         b = cyc;
         push_f(b + 43, 3'd3);
         push_a(b + 83, 3'd7);
         psfreq = 1'b1;
         psamp  = 1'b1;
         hold(40);
         psfreq = 1'b0;
         hold(40);
         psamp = 1'b0;
         hold(10);
      end
      do_reset("reset_after_nominal");

      // Tolerance edges on freq.
      b = cyc; push_f(b + 25, 3'd1);              frame(1'b0, 22, 92);
      b = cyc; push_f(b + 21, 3'd1);              frame(1'b0, 18, 90);
      b = cyc; push_err(b + 26, 2'b01, 3'd1, 3'd0); frame(1'b0, 23, 90);
      b = cyc; push_f(b + 53, 3'd4);              frame(1'b0, 50, 93);
      b = cyc;
      push_err(b + 3, 2'b01, 3'd4, 3'd0);
      push_f(b + 73, 3'd6);
      frame(1'b0, 70, 90);
      do_reset("reset_after_tolerance");

      // Stuck high after a good frame, then recovery.
      b = cyc; push_f(b + 63, 3'd5);              frame(1'b0, 60, 90);
      b = cyc; push_err(b + 86, 2'b01, 3'd5, 3'd0); frame(1'b0, 100, 130);
      b = cyc; push_f(b + 23, 3'd1);              frame(1'b0, 20, 90);
      do_reset("reset_after_stuck");

      // Timeout on both channels at once: one merged error pulse.
      b = cyc;
      push_f(b + 33, 3'd2);
      push_a(b + 63, 3'd5);
      push_err(b + 183, 2'b11, 3'd0, 3'd0);
      psfreq = 1'b1;
      psamp  = 1'b1;
      hold(30);
      psfreq = 1'b0;
      hold(30);
      psamp = 1'b0;
      hold(200);
      do_reset("reset_after_timeout");

      // Reset 20 clocks into a high pulse, line still high at release.
      b = cyc; push_f(b + 43, 3'd3);              frame(1'b0, 40, 90);
      psfreq = 1'b1;
      hold(20);
      reset = 1'b0;
      hold(3);
      chk("reset_mid_frame", outs(), 0);
      reset = 1'b1;
      hold(17);
      psfreq = 1'b0;
      hold(50);
      b = cyc; push_f(b + 73, 3'd6);              frame(1'b0, 70, 90);

      hold(5);
      chk("pending_events", q_f.size() + q_a.size() + q_e.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
